// File: rtl/ram_port_ctrl.sv
// Shared 64-bit data-RAM port controller: round-robin between fetch and LSU,
// with read-modify-write for byte/word stores so the RAM sees only dword writes.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   if_req/if_addr            - fetch request (read-only port 0)
//   if_ack/if_rdata           - fetch completion pulse, registered doubleword
//   ls_req/ls_we/ls_size      - load/store request, direction, size (00 d,01 b,10 w)
//   ls_addr/ls_wdata          - load/store byte address, right-aligned store data
//   ls_ack/ls_rdata           - load/store completion pulse, registered doubleword
//   ram_we/ram_addr/ram_wdata - RAM write enable, aligned address, full write data
//   ram_rdata                 - RAM combinational read data
module ram_port_ctrl #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [63:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [63:0]       ls_wdata,
    output logic              ls_ack,
    output logic [63:0]       ls_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [63:0]       ram_wdata,
    input  logic [63:0]       ram_rdata
);

    localparam int DATA_W = 64;
    localparam logic [1:0] SZ_D = 2'b00;
    localparam logic [1:0] SZ_B = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                last;
    logic                port_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   merge_q;
    logic [DATA_W-1:0]   merged;
    logic                req_any;
    logic                grant_ls;

    // Port 1 wins when it alone requests, or on a tie when fetch went last.
    always_comb begin
        req_any  = if_req | ls_req;
        grant_ls = (if_req & ls_req) ? ~last : ls_req;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    if (!grant_ls || !ls_we) begin
                        state_nx = RD;
                    end else begin
                        unique case (ls_size)
                            SZ_D:    state_nx = WR;
                            SZ_B:    state_nx = RMW_RD;
                            SZ_W:    state_nx = RMW_RD;
                            default: state_nx = DONE;
                        endcase
                    end
                end
            end
            RD:      state_nx = DONE;
            WR:      state_nx = DONE;
            RMW_RD:  state_nx = RMW_WR;
            RMW_WR:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            port_q   <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            if_rdata <= '0;
            ls_rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_any) begin
                port_q  <= grant_ls;
                last    <= grant_ls;
                addr_q  <= grant_ls ? ls_addr : if_addr;
                size_q  <= grant_ls ? ls_size : SZ_D;
                wdata_q <= grant_ls ? ls_wdata : '0;
            end
            if (state == RD) begin
                if (port_q) ls_rdata <= ram_rdata;
                else        if_rdata <= ram_rdata;
            end
            if (state == RMW_RD) merge_q <= ram_rdata;
        end
    end

    // Lane replacement on the doubleword captured in RMW_RD.
    always_comb begin
        merged = merge_q;
        if (size_q == SZ_B) begin
            merged[{addr_q[2:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[2], 5'b00000} +: 32] = wdata_q[31:0];
        end
    end

    // RAM pins depend only on state and latched fields.
    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = '0;
        ram_addr  = {addr_q[ADDR_W-1:3], 3'b000};
        if_ack    = 1'b0;
        ls_ack    = 1'b0;
        unique case (state)
            WR: begin
                ram_we    = 1'b1;
                ram_wdata = wdata_q;
            end
            RMW_WR: begin
                ram_we    = 1'b1;
                ram_wdata = merged;
            end
            DONE: begin
                if_ack = ~port_q;
                ls_ack = port_q;
            end
            default: ;
        endcase
    end

endmodule
